// File: rtl/uart_io_pkg.sv
// Shared definitions for the single-clock UART peripheral: core op encodings,
// TX/RX state enums and status register bit positions.
package uart_io_pkg;

   typedef enum logic [1:0] {
      UOP_NONE = 2'b00,
      UOP_RX   = 2'b01,
      UOP_TX   = 2'b10,
      UOP_STAT = 2'b11
   } uart_op_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   localparam int unsigned ST_RX_EMPTY  = 0;
   localparam int unsigned ST_RX_FULL   = 1;
   localparam int unsigned ST_TX_EMPTY  = 2;
   localparam int unsigned ST_TX_FULL   = 3;
   localparam int unsigned ST_OVERRUN   = 4;
   localparam int unsigned ST_FRAME_ERR = 5;
   localparam int unsigned ST_PAR_ERR   = 6;
   localparam int unsigned ST_TX_BUSY   = 7;

endpackage

// File: rtl/uart_io_unit_fifo.sv
// 8-bit synchronous byte FIFO with count-based full/empty; DEPTH is a power of two
// so the pointers wrap naturally.
module uart_byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       empty_o,
   output logic       full_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign data_o  = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   // a pop in the same cycle frees a slot, so a push while full still lands
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_io_unit.sv
// Single-clock UART peripheral: RX/TX byte FIFOs, baud timing, status and sticky errors.
// Define UART_IO_PARITY_EN for 8E1 frames with parity checking; default is 8N1.
module uart_io_unit
   import uart_io_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 868,
   parameter int unsigned RX_DEPTH = 8,
   parameter int unsigned TX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  op,
   input  logic [7:0]  wdata,
   output logic [31:0] rdata,
   output logic        stall,
   input  logic        rx,
   output logic        tx
);
   localparam int unsigned   CW        = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   uart_op_e   op_e;
   logic       rx_empty, rx_full, tx_empty, tx_full;
   logic       rx_pop, rx_push, tx_pop, tx_push;
   logic [7:0] rx_head, tx_head, status;

   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;

   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [1:0]    rx_sync_q;
   logic          rx_prev_q, rx_s;

   logic ovr_q, ovr_d, frm_q, frm_d, ovr_evt, frm_evt, stat_clr;
`ifdef UART_IO_PARITY_EN
   logic tx_par_q, tx_par_d, rx_par_ok_q, rx_par_ok_d;
   logic par_q, par_d, par_evt;
`endif

   assign op_e     = uart_op_e'(op);
   assign rx_pop   = (op_e == UOP_RX) && !rx_empty;
   assign tx_push  = (op_e == UOP_TX) && !tx_full;
   assign stall    = ((op_e == UOP_RX) && rx_empty) || ((op_e == UOP_TX) && tx_full);
   assign stat_clr = (op_e == UOP_STAT);

   always_comb begin
      case (op_e)
         UOP_RX:   rdata = {24'h0, rx_head};
         UOP_STAT: rdata = {24'h0, status};
         default:  rdata = '0;
      endcase
   end

   uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i(clk), .rst_ni(reset), .push_i(rx_push), .pop_i(rx_pop),
      .data_i(rx_shift_q), .data_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
   );

   uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i(clk), .rst_ni(reset), .push_i(tx_push), .pop_i(tx_pop),
      .data_i(wdata), .data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
   );

   // ---------------- transmitter ----------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      tx_cnt_d   = (tx_cnt_q == '0) ? BIT_LAST : tx_cnt_q - CW'(1);
`ifdef UART_IO_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = BIT_LAST;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
`ifdef UART_IO_PARITY_EN
               tx_par_d   = ^tx_head;
`endif
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == '0) begin
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
`ifdef UART_IO_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef UART_IO_PARITY_EN
         TX_PARITY: begin
            if (tx_cnt_q == '0) tx_state_d = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (tx_cnt_q == '0) begin
               // chain straight into the next start bit so frames run back to back
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
`ifdef UART_IO_PARITY_EN
                  tx_par_d   = ^tx_head;
`endif
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_state_q)
         TX_START:  tx = 1'b0;
         TX_DATA:   tx = tx_shift_q[0];
`ifdef UART_IO_PARITY_EN
         TX_PARITY: tx = tx_par_q;
`endif
         default:   tx = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   assign rx_s = rx_sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      ovr_evt    = 1'b0;
      frm_evt    = 1'b0;
      rx_cnt_d   = (rx_cnt_q == '0) ? BIT_LAST : rx_cnt_q - CW'(1);
`ifdef UART_IO_PARITY_EN
      rx_par_ok_d = rx_par_ok_q;
      par_evt     = 1'b0;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = HALF_LAST;
            if (rx_prev_q && !rx_s) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
`ifdef UART_IO_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_IO_PARITY_EN
         RX_PARITY: begin
            if (rx_cnt_q == '0) begin
               rx_par_ok_d = ((^rx_shift_q) == rx_s);
               rx_state_d  = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = RX_IDLE;
               if (!rx_s) frm_evt = 1'b1;
`ifdef UART_IO_PARITY_EN
               else if (!rx_par_ok_q) par_evt = 1'b1;
`endif
               else if (rx_full && !rx_pop) ovr_evt = 1'b1;
               else rx_push = 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- sticky flags and status ----------------
   assign ovr_d = ovr_evt | (ovr_q & ~stat_clr);
   assign frm_d = frm_evt | (frm_q & ~stat_clr);
`ifdef UART_IO_PARITY_EN
   assign par_d = par_evt | (par_q & ~stat_clr);
`endif

   always_comb begin
      status               = '0;
      status[ST_RX_EMPTY]  = rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_TX_FULL]   = tx_full;
      status[ST_OVERRUN]   = ovr_q;
      status[ST_FRAME_ERR] = frm_q;
`ifdef UART_IO_PARITY_EN
      status[ST_PAR_ERR]   = par_q;
`endif
      status[ST_TX_BUSY]   = (tx_state_q != TX_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_sync_q   <= '1;
         rx_prev_q   <= 1'b1;
         ovr_q       <= 1'b0;
         frm_q       <= 1'b0;
`ifdef UART_IO_PARITY_EN
         tx_par_q    <= 1'b0;
         rx_par_ok_q <= 1'b0;
         par_q       <= 1'b0;
`endif
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_sync_q   <= {rx_sync_q[0], rx};
         rx_prev_q   <= rx_sync_q[1];
         ovr_q       <= ovr_d;
         frm_q       <= frm_d;
`ifdef UART_IO_PARITY_EN
         tx_par_q    <= tx_par_d;
         rx_par_ok_q <= rx_par_ok_d;
         par_q       <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_io_unit.sv
// Scoreboard bench for uart_io_unit (BAUD_DIV=4, depths 4); rdata and serial tx are
// checked by monitors against queues filled by the stimulus tasks.
`timescale 1ns/1ps
module tb_uart_io_unit;
   import uart_io_pkg::*;

   localparam int unsigned BD = 4;
`ifdef UART_IO_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * BD;

   typedef struct {
      logic [7:0] v;
      string      n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [7:0]  wdata = 8'h00;
   logic [31:0] rdata;
   logic        stall;
   logic        rx, tx;
   logic        loop = 1'b1;
   logic        rx_ext = 1'b1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   prev_start = -1;
   bit   mon_en = 1'b0;
   bit   b2b = 1'b0;
   exp_t rd_q[$];
   logic [7:0] tx_q[$];

   assign rx = loop ? tx : rx_ext;

   uart_io_unit #(.BAUD_DIV(BD), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .op(op), .wdata(wdata), .rdata(rdata),
      .stall(stall), .rx(rx), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for DUT, got stall expected completion", nm);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // all drive tasks start and end at posedge+1
   task automatic do_write(input logic [7:0] b, input logic exp_stall, input string nm);
      int n = 0;
      op = UOP_TX;
      wdata = b;
      @(negedge clk);
      check({nm, "_stall"}, stall, exp_stall);
      while (stall && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (stall) timeout(nm);
      else tx_q.push_back(b);
      @(posedge clk); #1;
      op = UOP_NONE;
   endtask

   task automatic do_read(input logic [7:0] b, input int exp_stall, input string nm);
      exp_t e;
      int n = 0;
      e.v = b;
      e.n = nm;
      rd_q.push_back(e);
      op = UOP_RX;
      @(negedge clk);
      if (exp_stall >= 0) check({nm, "_stall"}, stall, exp_stall[0]);
      while (stall && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (stall) begin
         timeout(nm);
         void'(rd_q.pop_back());
      end
      @(posedge clk); #1;
      op = UOP_NONE;
   endtask

   task automatic do_stat(input logic [7:0] b, input string nm);
      exp_t e;
      e.v = b;
      e.n = nm;
      rd_q.push_back(e);
      op = UOP_STAT;
      @(negedge clk);
      check({nm, "_stall"}, stall, 1'b0);
      @(posedge clk); #1;
      op = UOP_NONE;
   endtask

   task automatic drive_bit(input logic v);
      rx_ext = v;
      repeat (BD) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic corrupt);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_IO_PARITY_EN
      drive_bit((^b) ^ corrupt);
`else
      if (corrupt) drive_bit(1'b0);
`endif
      drive_bit(stop);
      drive_bit(1'b1);
   endtask

   // rdata monitor: every completed RX/status access consumes one expectation
   always @(negedge clk) begin
      if (reset && (op == UOP_RX || op == UOP_STAT) && !stall) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdata_unexpected: got 0x%0h expected no access", rdata);
         end else begin
            exp_t e;
            e = rd_q.pop_front();
            check(e.n, rdata, {24'h0, e.v});
         end
      end
   end

   // serial monitor: decodes frames on tx at mid-bit and checks against tx_q
   initial begin : tx_mon
      logic [7:0] b;
      logic [7:0] e;
      int st;
      forever begin
         @(negedge clk);
         if (mon_en && reset && tx === 1'b0) begin
            st = cyc;
            if (b2b && prev_start >= 0) check("tx_b2b_gap", st - prev_start, FRAME);
            prev_start = st;
            repeat (BD / 2) @(negedge clk);
            check("tx_start_bit", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = tx;
            end
`ifdef UART_IO_PARITY_EN
            repeat (BD) @(negedge clk);
            check("tx_parity", tx, ^b);
`endif
            repeat (BD) @(negedge clk);
            check("tx_stop_bit", tx, 1'b1);
            if (tx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected: got 0x%0h expected no frame", b);
            end else begin
               e = tx_q.pop_front();
               check("tx_byte", b, e);
            end
         end
      end
   end

   initial begin : main
      logic [7:0] a5;
      logic       wave [FRAME + 1];
      logic [7:0] seq [7];
      logic       sexp [7];
      int         n;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(3);

      // 1: reset mid-frame, then reset state
      op = UOP_TX;
      wdata = 8'h55;
      @(posedge clk); #1;
      op = UOP_NONE;
      @(posedge clk); #3;
      check("t1_tx_start", tx, 1'b0);
      reset = 1'b0;
      #1;
      check("t1_tx_reset", tx, 1'b1);
      check("t1_stall_reset", stall, 1'b0);
      check("t1_rdata_reset", rdata, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      mon_en = 1'b1;
      do_stat(8'h05, "t1_status");

      // 2: A5 waveform with loopback off
      loop = 1'b0;
      a5 = 8'hA5;
      for (int i = 0; i <= FRAME; i++) begin
         if (i < BD) wave[i] = 1'b0;
         else if (i < 9 * BD) wave[i] = a5[(i - BD) / BD];
         else if (NBITS == 11 && i < 10 * BD) wave[i] = ^a5;
         else wave[i] = 1'b1;
      end
      do_write(8'hA5, 1'b0, "t2_wr");
      fork
         begin
            @(posedge clk);
            for (int i = 0; i <= FRAME; i++) begin
               @(negedge clk);
               check("t2_wave", tx, wave[i]);
            end
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            do_stat(8'h85, "t2_status_busy");
         end
      join
      @(posedge clk); #1;
      do_stat(8'h05, "t2_status_done");

      // 3: loopback round trip
      loop = 1'b1;
      do_write(8'h3C, 1'b0, "t3_wr");
      idle(FRAME + 5);
      do_read(8'h3C, 0, "t3_rd");
      do_stat(8'h05, "t3_status");

      // 4: read held while RX empty until the byte lands
      do_write(8'h81, 1'b0, "t4_wr");
      do_read(8'h81, 1, "t4_rd");
      do_stat(8'h05, "t4_status");

      // 5: external rx: overrun, glitch, frame error
      loop = 1'b0;
      rx_ext = 1'b1;
      idle(4);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0);
      do_stat(8'h16, "t5_status_ovr");
      do_stat(8'h06, "t5_status_ovr_clr");
      do_read(8'h11, 0, "t5_rd0");
      do_read(8'h22, 0, "t5_rd1");
      do_read(8'h33, 0, "t5_rd2");
      do_read(8'h44, 0, "t5_rd3");
      do_stat(8'h05, "t5_status_empty");
      rx_ext = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rx_ext = 1'b1;
      idle(20);
      do_stat(8'h05, "t5_status_glitch");
      send_frame(8'h5A, 1'b0, 1'b0);
      do_stat(8'h25, "t5_status_frm");
      do_stat(8'h05, "t5_status_frm_clr");
`ifdef UART_IO_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      do_stat(8'h45, "t5_status_par");
      do_stat(8'h05, "t5_status_par_clr");
      send_frame(8'h07, 1'b1, 1'b0);
      do_read(8'h07, 0, "t5_rd_par_ok");
`endif

      // 6: seven back-to-back writes into a depth-4 FIFO
      rx_ext = 1'b1;
      b2b = 1'b1;
      prev_start = -1;
      for (int i = 0; i < 7; i++) begin
         seq[i] = 8'(i + 1);
         sexp[i] = (i >= 5);
      end
      for (int i = 0; i < 7; i++) do_write(seq[i], sexp[i], "t6_wr");
      n = 0;
      while (tx_q.size() != 0 && n < 8 * FRAME) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (tx_q.size() != 0) timeout("t6_drain");
      idle(FRAME);
      b2b = 1'b0;
      do_stat(8'h05, "t6_status");

      idle(4);
      check("rd_q_drained", rd_q.size(), 0);
      check("tx_q_drained", tx_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
